// File: rtl/tx_serial_uart_param_if.sv
// Write-side bus of the serial transmitter: data word, write strobe and the
// FIFO status flags returned to the producer.
interface tx_serial_uart_param_if #(
  parameter int DATA_BITS = 7
);
  logic [DATA_BITS-1:0] dados;
  logic                 escreve;
  logic                 cheio;
  logic                 vazio;

  modport master (output dados, output escreve, input cheio, input vazio);
  modport slave  (input dados, input escreve, output cheio, output vazio);
endinterface

// File: rtl/tx_serial_uart_param.sv
// Buffered asynchronous serial transmitter with compile-time frame format.
//
// state     | code | meaning
// INICIAL   | 0    | idle, line high, waiting for a queued word
// PREPARA   | 1    | pop FIFO head, load the whole frame into the shifter
// TRANSMITE | 2    | shifter bit 0 drives the line, shift once per baud tick
// FINAL     | 3    | one-cycle end-of-frame, pronto pulses here
module tx_serial_uart_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 7,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  tx_serial_uart_param_if.slave  bus,
  output logic                   saida_serial,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [3:0]             db_estado,
  output logic [3:0]             db_contagem
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PB  = (PARITY != 0) ? 1 : 0;
  localparam int F   = 1 + DATA_BITS + PB + STOP_BITS;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    TRANSMITE = 4'd2,
    FINAL     = 4'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [F-1:0]           shift_q, shift_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic                   saida_q, saida_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   cheio, vazio, push, pop, tick, par;
  logic [DATA_BITS-1:0]   head;
  logic [F-1:0]           frame;

  assign cheio = (cnt_q == CW'(FIFO_DEPTH));
  assign vazio = (cnt_q == '0);
  // a write while full is dropped even if a pop happens in the same cycle
  assign push  = bus.escreve & ~cheio;
  assign pop   = (state_q == PREPARA) & ~vazio;
  assign tick  = (tick_q == TW'(DIV - 1));
  assign head  = mem_q[rd_q];

  // FIFO next-state: storage, wrapping pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = bus.dados;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Assemble the full frame from the FIFO head, start bit in bit 0
  always_comb begin
    par              = (^head) ^ (PARITY == 2);
    frame            = '1;
    frame[0]         = 1'b0;
    frame[DATA_BITS:1] = head;
    if (PB == 1) begin
      frame[DATA_BITS+1] = par;
    end
  end

  // Sequencer next-state, shifter, baud tick and bit counter
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    case (state_q)
      INICIAL: begin
        if (!vazio) state_d = PREPARA;
      end
      PREPARA: begin
        shift_d = frame;
        tick_d  = '0;
        bit_d   = '0;
        state_d = TRANSMITE;
      end
      TRANSMITE: begin
        if (tick) begin
          tick_d  = '0;
          shift_d = {1'b1, shift_q[F-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(F - 1)) state_d = FINAL;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      FINAL: begin
        state_d = vazio ? INICIAL : PREPARA;
      end
      default: state_d = INICIAL;
    endcase
    // line is registered: it follows the shifter only while transmitting
    saida_d = (state_d == TRANSMITE) ? shift_d[0] : 1'b1;
  end

  // Control and FIFO bookkeeping registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= INICIAL;
      shift_q <= '1;
      tick_q  <= '0;
      bit_q   <= '0;
      saida_q <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      saida_q <= saida_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until the counter says otherwise
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.cheio    = cheio;
  assign bus.vazio    = vazio;
  assign saida_serial = saida_q;
  // held low while reset is asserted so no end-of-frame pulse leaks out
  assign ocupado      = reset & (state_q inside {PREPARA, TRANSMITE, FINAL});
  assign pronto       = reset & (state_q == FINAL);
  assign db_estado    = state_q;
  assign db_contagem  = bit_q;

endmodule

// File: tb/tb_tx_serial_uart_param.sv
// Bench for tx_serial_uart_param: three frame formats side by side, each
// checked cycle by cycle against a timeline model built from frame rules.
module tb_tx_serial_uart_param;

  localparam int NU   = 3;
  localparam int MAXC = 2000;
  localparam int CLKA  [NU] = '{1000, 400, 350};
  localparam int BAUDA [NU] = '{100, 100, 100};
  localparam int DBA   [NU] = '{7, 8, 5};
  localparam int PARA  [NU] = '{2, 1, 0};
  localparam int SBA   [NU] = '{1, 2, 1};
  localparam int DEPA  [NU] = '{4, 4, 2};

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [8:0] din [NU];
  logic [NU-1:0] esc;
  logic [NU-1:0] line, prt, ocp, chf, vzf;
  logic [3:0] est [NU];
  logic [3:0] cnt [NU];

  int n_tests = 0;
  int n_fail  = 0;

  bit wr_en [MAXC];
  int wr_w  [MAXC];

  always #5 clk = ~clk;

  tx_serial_uart_param_if #(.DATA_BITS(7)) if0 ();
  tx_serial_uart_param_if #(.DATA_BITS(8)) if1 ();
  tx_serial_uart_param_if #(.DATA_BITS(5)) if2 ();

  assign if0.dados = din[0][6:0];
  assign if1.dados = din[1][7:0];
  assign if2.dados = din[2][4:0];
  assign if0.escreve = esc[0];
  assign if1.escreve = esc[1];
  assign if2.escreve = esc[2];
  assign chf = {if2.cheio, if1.cheio, if0.cheio};
  assign vzf = {if2.vazio, if1.vazio, if0.vazio};

  tx_serial_uart_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clock(clk), .reset(rst_b), .bus(if0.slave), .saida_serial(line[0]),
    .ocupado(ocp[0]), .pronto(prt[0]), .db_estado(est[0]), .db_contagem(cnt[0]));

  tx_serial_uart_param #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clock(clk), .reset(rst_b), .bus(if1.slave), .saida_serial(line[1]),
    .ocupado(ocp[1]), .pronto(prt[1]), .db_estado(est[1]), .db_contagem(cnt[1]));

  tx_serial_uart_param #(.CLK_FREQ(350), .BAUD_RATE(100), .DATA_BITS(5),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut2 (
    .clock(clk), .reset(rst_b), .bus(if2.slave), .saida_serial(line[2]),
    .ocupado(ocp[2]), .pronto(prt[2]), .db_estado(est[2]), .db_contagem(cnt[2]));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int u);
    return CLKA[u] / BAUDA[u];
  endfunction

  function automatic int flen(input int u);
    return 1 + DBA[u] + ((PARA[u] != 0) ? 1 : 0) + SBA[u];
  endfunction

  // line level of bit i (line order) of the frame carrying word w
  function automatic int exp_bit(input int u, input int w, input int i);
    int ones;
    ones = $countones(w) & 1;
    if (i == 0) return 0;
    if (i <= DBA[u]) return (w >> (i - 1)) & 1;
    if (i == DBA[u] + 1 && PARA[u] != 0) return (PARA[u] == 1) ? ones : 1 - ones;
    return 1;
  endfunction

  function automatic void clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      wr_en[i] = 1'b0;
      wr_w[i]  = 0;
    end
  endfunction

  // Plays the write schedule into unit u for ncyc edges (unit idle and empty
  // on entry). Model: queue of accepted words; a frame starts at the edge its
  // word is popped and lasts F*DIV cycles; FINAL is the following cycle.
  task automatic run(input int u, input int ncyc, input string nm);
    int q[$];
    int dv, f, dep, mask, pop_at, s, fe, cw, t;
    bit full, in_tx, fin, prep;
    int e_line, e_st;
    dv = div_of(u); f = flen(u); dep = DEPA[u];
    mask = (1 << DBA[u]) - 1;
    pop_at = -1; s = -100000; fe = -100000; cw = 0;
    for (t = 0; t < ncyc; t++) begin
      esc[u] = wr_en[t];
      din[u] = 9'(wr_w[t]);
      @(posedge clk);
      #1;
      full = (q.size() == dep);
      if (t == pop_at) begin
        cw = q.pop_front();
        s = t; fe = t + f * dv; pop_at = -1;
      end
      if (wr_en[t] && !full) q.push_back(wr_w[t] & mask);
      in_tx = (t >= s) && (t < fe);
      fin   = (t == fe);
      prep  = (pop_at == t + 1);
      e_line = in_tx ? exp_bit(u, cw, (t - s) / dv) : 1;
      e_st   = prep ? 1 : in_tx ? 2 : fin ? 3 : 0;
      check($sformatf("%s u%0d t%0d line", nm, u, t), 16'(line[u]), 16'(e_line));
      check($sformatf("%s u%0d t%0d pronto", nm, u, t), 16'(prt[u]), 16'(fin));
      check($sformatf("%s u%0d t%0d ocupado", nm, u, t), 16'(ocp[u]), 16'(prep || in_tx || fin));
      check($sformatf("%s u%0d t%0d cheio", nm, u, t), 16'(chf[u]), 16'(q.size() == dep));
      check($sformatf("%s u%0d t%0d vazio", nm, u, t), 16'(vzf[u]), 16'(q.size() == 0));
      check($sformatf("%s u%0d t%0d estado", nm, u, t), 16'(est[u]), 16'(e_st));
      if (in_tx || fin)
        check($sformatf("%s u%0d t%0d contagem", nm, u, t), 16'(cnt[u]),
              16'(in_tx ? (t - s) / dv : f));
      if (pop_at < 0 && t >= fe && q.size() > 0) pop_at = t + 2;
    end
    esc[u] = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("%s u%0d line", nm, u), 16'(line[u]), 16'(1));
      check($sformatf("%s u%0d vazio", nm, u), 16'(vzf[u]), 16'(1));
      check($sformatf("%s u%0d cheio", nm, u), 16'(chf[u]), 16'(0));
      check($sformatf("%s u%0d estado", nm, u), 16'(est[u]), 16'(0));
      check($sformatf("%s u%0d pronto", nm, u), 16'(prt[u]), 16'(0));
      check($sformatf("%s u%0d ocupado", nm, u), 16'(ocp[u]), 16'(0));
    end
  endtask

  initial begin
    int ncyc;
    esc = '0;
    for (int u = 0; u < NU; u++) din[u] = '0;

    // reset held for 3 edges, then released
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle($sformatf("rst%0d", i));
      for (int u = 0; u < NU; u++)
        check($sformatf("rst%0d u%0d contagem", i, u), 16'(cnt[u]), 16'(0));
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_idle("rel");

    // single frames with the reference words
    clear_sched(); wr_en[0] = 1; wr_w[0] = 'h41;
    run(0, 115, "w41");
    clear_sched(); wr_en[0] = 1; wr_w[0] = 'hFF;
    run(1, 60, "wFF");
    clear_sched(); wr_en[0] = 1; wr_w[0] = 'h01;
    run(1, 60, "w01");
    clear_sched(); wr_en[0] = 1; wr_w[0] = 'h15;
    run(2, 30, "w15");

    // burst of 6 consecutive writes into depth-4 FIFO: 5 accepted, 6th dropped
    clear_sched();
    for (int i = 0; i < 6; i++) begin
      wr_en[i] = 1; wr_w[i] = int'($urandom_range(0, 127));
    end
    run(0, 5 * (flen(0) * div_of(0) + 2) + 20, "burst");

    // write coinciding with PREPARA at occupancy 2
    clear_sched();
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 1; wr_w[i] = int'($urandom_range(0, 127));
    end
    run(0, 3 * (flen(0) * div_of(0) + 2) + 20, "simul");

    // overflow on the depth-2 unit: writes over several cycles while full
    clear_sched();
    for (int i = 0; i < 5; i++) begin
      wr_en[i] = 1; wr_w[i] = int'($urandom_range(0, 31));
    end
    run(2, 4 * (flen(2) * div_of(2) + 2) + 20, "ovf2");

    // random write traffic on each format
    for (int u = 0; u < NU; u++) begin
      for (int r = 0; r < 2; r++) begin
        clear_sched();
        for (int i = 0; i < 200; i++) begin
          wr_en[i] = ($urandom_range(0, 5 + 3 * r) == 0);
          wr_w[i]  = int'($urandom);
        end
        ncyc = 200 + (DEPA[u] + 1) * (flen(u) * div_of(u) + 2) + 10;
        run(u, ncyc, $sformatf("rnd%0d", r));
      end
    end

    // reset with a frame in flight and a word still queued
    clear_sched(); wr_en[0] = 1; wr_w[0] = 'h00; wr_en[1] = 1; wr_w[1] = 'h55;
    run(0, 30, "pre_rst");
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("midrst line", 16'(line[0]), 16'(1));
    check("midrst vazio", 16'(vzf[0]), 16'(1));
    check("midrst estado", 16'(est[0]), 16'(0));
    check("midrst pronto", 16'(prt[0]), 16'(0));
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      check($sformatf("postrst t%0d line", i), 16'(line[0]), 16'(1));
      check($sformatf("postrst t%0d pronto", i), 16'(prt[0]), 16'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_serial_uart_param.md
# tx_serial_uart_param

Parametrised, buffered asynchronous serial transmitter: the next generation of the fixed 7O1 transmitter. It accepts words through a small write-side FIFO and frames each word on `saida_serial`. The frame format (data width, parity mode, stop bits) and the baud divisor are compile-time parameters. It sits between the application logic and the serial line pin/GPIO and exposes the same debug-style outputs as the existing transmitters.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate. Divisor `DIV = CLK_FREQ / BAUD_RATE`, integer floor, must be ≥ 2.
- `DATA_BITS`, 7: data bits per frame, legal range 5..9.
- `PARITY`, 2: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: entries in the write FIFO; must be a power of two, ≥ 2.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `dados` in DATA_BITS: word to transmit.
- `escreve` in 1: write strobe. Pushes `dados` when `cheio`=0.
- `cheio` out 1: FIFO full.
- `vazio` out 1: FIFO empty.
- `saida_serial` out 1: serial line, registered, idle high.
- `ocupado` out 1: high while a frame is being prepared or sent.
- `pronto` out 1: one-cycle pulse at the end of each frame.
- `db_estado` out 4: FSM state code.
- `db_contagem` out 4: bits already shifted out in the current frame.

## Operation
- **Frame, in line order:** start bit (0), data bits LSB first, optional parity bit, then `STOP_BITS` stop bits (1).
  - Frame length `F = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS`.
- **Parity:** computed over the data bits. Even mode sends the XOR of the data bits; odd mode sends its inverse.
- **FIFO:**
  - Push when `escreve`=1 and `cheio`=0, sampled before the edge.
  - A write while `cheio`=1 is dropped, even if a pop happens in the same cycle. No overwrite; stored data is unchanged.
  - Pop happens only in PREPARA.
  - Read and write pointers wrap modulo `FIFO_DEPTH`. The occupancy counter runs 0..`FIFO_DEPTH`.
- **FSM states (codes):**
  - INICIAL (0):
    - If `vazio`=0, go to PREPARA; otherwise stay.
  - PREPARA (1):
    - Pop the FIFO head.
    - Load shift register with the full frame, `F` bits, bit 0 = start.
    - Zero the tick counter and the bit counter. Go to TRANSMITE.
  - TRANSMITE (2):
    - `saida_serial` is driven from shift register bit 0.
    - On each tick: shift right, filling with 1, and increment the bit counter.
    - When the bit counter reaches `F`, go to FINAL.
  - FINAL (3):
    - `pronto`=1 for this cycle only.
    - Go to PREPARA if `vazio`=0, else INICIAL.
  - Codes 4..15 are unused. Any illegal state returns to INICIAL on the next edge.
- **Tick generator:**
  - Modulo-`DIV` counter, width `$clog2(DIV)`, running only in TRANSMITE and zeroed in PREPARA.
  - The tick fires on count `DIV-1`, so every bit lasts exactly `DIV` cycles.
- **Output decodes:**
  - `ocupado` = state ∈ {PREPARA, TRANSMITE, FINAL}.
  - `saida_serial` = 1 outside TRANSMITE.

## Timing
- **Values during and right after reset:**
  - `saida_serial`=1, `pronto`=0, `ocupado`=0.
  - `vazio`=1, `cheio`=0, `db_estado`=0, `db_contagem`=0.
  - FIFO pointers and counters are cleared.
- **Latency, write into an empty FIFO while idle:**
  - Push at edge k; `vazio` falls after edge k.
  - PREPARA after edge k+1.
  - Start bit on the line from edge k+2.
- **Frame duration:** the line is low from edge s, the start bit lasts `DIV` cycles, and the last stop bit ends at edge s+F·DIV. FINAL occupies the cycle after that edge.
- **Back-to-back frames:** the line stays high 2 extra cycles between frames (FINAL, then PREPARA), i.e. the last stop bit is stretched by 2 clocks. No other gap.
- **Reset mid-frame:** at the reset edge the line returns high and queued words are discarded. No `pronto` pulse is emitted.
- **Simultaneous write and pop when not full:** both take effect; occupancy is unchanged.
- **Full to non-full:** `cheio` falls on the edge after a pop.

## Test plan
- **Idle/reset:** hold `reset`=0 for 3 cycles, then release → `saida_serial`=1, `vazio`=1, `db_estado`=0. Repeat with a frame in flight → line high on the edge after `reset`=0.
- **7O1, `CLK_FREQ`=1000, `BAUD_RATE`=100 (DIV=10):** write 0x41 → line reads 0,1,0,0,0,0,0,1,1,1, each bit 10 cycles. The start bit begins 2 edges after the write edge. A single `pronto` pulse follows, 100 cycles after the start edge.
- **8E2 (`DATA_BITS`=8, `PARITY`=1, `STOP_BITS`=2):** write 0xFF → 0, eight 1s, parity 0, 1, 1. Write 0x01 → parity 1. `F`=12.
- **No parity, 5 data bits:** write 0x15 → 0,1,0,1,0,1,1. `F`=7.
- **FIFO burst, depth 4:** write 6 words in consecutive cycles → FIFO accepts 5 (one popped in PREPARA frees a slot) and drops the 6th when `cheio`=1.
  - Five frames go out in order, each separated by exactly 2 high cycles.
  - `cheio` and `vazio` toggle on the edges predicted by the FIFO and timing rules.
- **Simultaneous write and pop:** write in the same cycle as PREPARA with occupancy 2 → occupancy stays 2 and no data is lost or duplicated.
